// File: rtl/asym_fifo_pkg.sv
// Shared widths, ratio helper and read-FSM encoding for the asymmetric FIFO controller.
package asym_fifo_pkg;

  localparam int unsigned WIDTHA_DEF     = 8;
  localparam int unsigned WIDTHB_DEF     = 32;
  localparam int unsigned ADDRWIDTHA_DEF = 8;
  localparam int unsigned ADDRWIDTHB_DEF = 6;

  // log2 of the wide/narrow width ratio; the ratio is expected to be a power of 2.
  function automatic int unsigned ratio_log2(input int unsigned wa, input int unsigned wb);
    return $clog2(wb / wa);
  endfunction

  localparam int unsigned LOG2_RATIO_DEF = ratio_log2(WIDTHA_DEF, WIDTHB_DEF);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_VALID = 1'b1;

endpackage

// File: rtl/asym_fifo_ptr.sv
// Write/read pointers, occupancy and word-availability flags for the asymmetric FIFO.
module asym_fifo_ptr
  import asym_fifo_pkg::*;
#(
  parameter int unsigned ADDRWIDTHA = ADDRWIDTHA_DEF,
  parameter int unsigned ADDRWIDTHB = ADDRWIDTHB_DEF,
  parameter int unsigned LOG2R      = LOG2_RATIO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_fire,
  input  logic                  rd_pop,
  output logic [ADDRWIDTHA-1:0] wr_addr,
  output logic [ADDRWIDTHB-1:0] rd_addr,
  output logic [ADDRWIDTHB-1:0] rd_addr_nxt,
  output logic [ADDRWIDTHA:0]   fill_bytes,
  output logic                  wr_ready,
  output logic                  avail,
  output logic                  avail_after_pop
);

  localparam logic [ADDRWIDTHA:0] DEPTH  = (ADDRWIDTHA+1)'(1 << ADDRWIDTHA);
  localparam logic [ADDRWIDTHA:0] WR_ONE = (ADDRWIDTHA+1)'(1);
  localparam logic [ADDRWIDTHB:0] RD_ONE = (ADDRWIDTHB+1)'(1);

  logic [ADDRWIDTHA:0] wr_ptr;
  logic [ADDRWIDTHB:0] rd_ptr;
  logic [ADDRWIDTHB:0] rd_ptr_inc;
  logic [ADDRWIDTHA:0] rd_bytes;
  logic [ADDRWIDTHB:0] wr_words;

  assign rd_ptr_inc  = rd_ptr + RD_ONE;
  assign rd_bytes    = (ADDRWIDTHA+1)'(rd_ptr) << LOG2R;
  assign wr_words    = wr_ptr[ADDRWIDTHA:LOG2R];

  assign fill_bytes  = wr_ptr - rd_bytes;
  assign wr_ready    = (fill_bytes != DEPTH);
  // Only complete wide words count; a partial word never becomes readable.
  assign avail           = (wr_words != rd_ptr);
  assign avail_after_pop = (wr_words != rd_ptr_inc);

  assign wr_addr     = wr_ptr[ADDRWIDTHA-1:0];
  assign rd_addr     = rd_ptr[ADDRWIDTHB-1:0];
  assign rd_addr_nxt = rd_ptr_inc[ADDRWIDTHB-1:0];

  // Pointer update; both may advance in the same cycle, reset wins over either.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + WR_ONE;
      if (rd_pop)  rd_ptr <= rd_ptr_inc;
    end
  end

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Narrow-in / wide-out FIFO sequencer for an external asymmetric dual-port RAM.
module asym_fifo_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WIDTHA     = WIDTHA_DEF,
  parameter int unsigned WIDTHB     = WIDTHB_DEF,
  parameter int unsigned ADDRWIDTHA = ADDRWIDTHA_DEF,
  parameter int unsigned ADDRWIDTHB = ADDRWIDTHB_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTHA-1:0]     wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTHB-1:0]     rd_data,
  output logic [ADDRWIDTHA:0]   fill_bytes,
  output logic                  ram_enA,
  output logic                  ram_weA,
  output logic [ADDRWIDTHA-1:0] ram_addrA,
  output logic [WIDTHA-1:0]     ram_diA,
  output logic                  ram_enB,
  output logic                  ram_weB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [WIDTHB-1:0]     ram_doB
);

  localparam int unsigned LOG2R = ratio_log2(WIDTHA, WIDTHB);

  logic                  state;
  logic                  state_nxt;
  logic                  wr_fire;
  logic                  rd_pop;
  logic                  avail;
  logic                  avail_after_pop;
  logic [ADDRWIDTHA-1:0] wr_addr;
  logic [ADDRWIDTHB-1:0] rd_addr;
  logic [ADDRWIDTHB-1:0] rd_addr_nxt;

  asym_fifo_ptr #(
    .ADDRWIDTHA (ADDRWIDTHA),
    .ADDRWIDTHB (ADDRWIDTHB),
    .LOG2R      (LOG2R)
  ) u_ptr (
    .clk             (clk),
    .rst             (rst),
    .wr_fire         (wr_fire),
    .rd_pop          (rd_pop),
    .wr_addr         (wr_addr),
    .rd_addr         (rd_addr),
    .rd_addr_nxt     (rd_addr_nxt),
    .fill_bytes      (fill_bytes),
    .wr_ready        (wr_ready),
    .avail           (avail),
    .avail_after_pop (avail_after_pop)
  );

  assign wr_fire   = wr_valid & wr_ready & ~rst;
  assign ram_enA   = wr_fire;
  assign ram_weA   = wr_fire;
  assign ram_addrA = wr_addr;
  assign ram_diA   = wr_data;
  assign ram_weB   = 1'b0;
  assign rd_valid  = (state == ST_VALID);
  assign rd_data   = ram_doB;

  // Read sequencing: prefetch one wide word into the RAM output register and hold it there
  // (port B disabled) until the consumer takes it.
  always_comb begin
    state_nxt = state;
    ram_enB   = 1'b0;
    ram_addrB = rd_addr;
    rd_pop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (avail) begin
          ram_enB   = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (rd_ready) begin
          rd_pop = 1'b1;
          if (avail_after_pop) begin
            ram_enB   = 1'b1;
            ram_addrB = rd_addr_nxt;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      ram_enB = 1'b0;
      rd_pop  = 1'b0;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Bench for asym_fifo_ctrl: behavioural asymmetric RAM, queue scoreboard and directed sequences.
module tb_asym_fifo_ctrl;

  localparam int unsigned WA = 8;
  localparam int unsigned WB = 32;
  localparam int unsigned AA = 8;
  localparam int unsigned AB = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [WA-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [WB-1:0] rd_data;
  logic [AA:0]   fill_bytes;
  logic          ram_enA, ram_weA, ram_enB, ram_weB;
  logic [AA-1:0] ram_addrA;
  logic [WA-1:0] ram_diA;
  logic [AB-1:0] ram_addrB;
  logic [WB-1:0] ram_doB;

  always #5 clk = ~clk;

  asym_fifo_ctrl #(
    .WIDTHA     (WA),
    .WIDTHB     (WB),
    .ADDRWIDTHA (AA),
    .ADDRWIDTHB (AB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .fill_bytes (fill_bytes),
    .ram_enA    (ram_enA),
    .ram_weA    (ram_weA),
    .ram_addrA  (ram_addrA),
    .ram_diA    (ram_diA),
    .ram_enB    (ram_enB),
    .ram_weB    (ram_weB),
    .ram_addrB  (ram_addrB),
    .ram_doB    (ram_doB)
  );

  // Asymmetric RAM: byte-wide write port, 32-bit registered read port, lane 0 = lowest byte.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_enA && ram_weA) mem[ram_addrA] <= ram_diA;
    if (ram_enB) ram_doB <= {mem[{ram_addrB, 2'd3}], mem[{ram_addrB, 2'd2}],
                             mem[{ram_addrB, 2'd1}], mem[{ram_addrB, 2'd0}]};
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];
  int m_fill = 0;
  int m_nb = 0;
  logic [31:0] m_acc = '0;
  logic [7:0] m_wcnt = '0;
  int pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte occupancy, word assembly and expected-word queue, sampled on negedge.
  always @(negedge clk) begin : monitor
    logic fire, pop;
    if (rst) begin
      sb.delete();
      m_fill = 0;
      m_nb   = 0;
      m_acc  = '0;
      m_wcnt = '0;
    end else begin
      fire = wr_valid && (m_fill != 256);
      pop  = rd_valid && rd_ready;
      check("wr_ready", 64'(wr_ready), 64'(m_fill != 256));
      check("fill_bytes", 64'(fill_bytes), 64'(m_fill));
      check("ram_enA", 64'(ram_enA), 64'(fire));
      check("ram_weA", 64'(ram_weA), 64'(fire));
      check("ram_weB", 64'(ram_weB), 64'(0));
      if (fire) begin
        check("ram_addrA", 64'(ram_addrA), 64'(m_wcnt));
        check("ram_diA", 64'(ram_diA), 64'(wr_data));
      end
      if (pop) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_pop_empty: got rd_valid=1 expected no word available");
        end else begin
          check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
          pops++;
        end
        m_fill -= 4;
      end
      if (fire) begin
        m_acc[m_nb*8 +: 8] = wr_data;
        m_nb++;
        if (m_nb == 4) begin
          sb.push_back(m_acc);
          m_nb = 0;
        end
        m_fill++;
        m_wcnt++;
      end
    end
  end

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        rr;
    logic [8:0]  fill;
    logic        wrdy;
    logic        rv;
    logic        chk;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, output int n);
    rd_ready = 1'b1;
    wr_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_empty"}, 64'(sb.size()), 64'(0));
    tick();
    tick();
    check({name, "_rd_valid"}, 64'(rd_valid), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1'b1, 8'h11, 1'b1, 9'd1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 9'd2, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 8'h33, 1'b1, 9'd3, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 9'd3, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 9'd3, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 8'h44, 1'b1, 9'd4, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 9'd4, 1'b1, 1'b1, 1'b1, 32'h44332211};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 32'h0};

    // Reset state
    do_reset();
    check("rst_fill", 64'(fill_bytes), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(1));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_enA", 64'(ram_enA), 64'(0));
    check("rst_enB", 64'(ram_enB), 64'(0));

    // Partial word stays invisible; the 4th byte makes one word readable two cycles later
    for (int i = 0; i < 8; i++) begin
      wr_valid = tbl[i].wv;
      wr_data  = tbl[i].wd;
      rd_ready = tbl[i].rr;
      tick();
      check($sformatf("vec%0d_fill", i), 64'(fill_bytes), 64'(tbl[i].fill));
      check($sformatf("vec%0d_wr_ready", i), 64'(wr_ready), 64'(tbl[i].wrdy));
      check($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].rv));
      if (tbl[i].chk) check($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(tbl[i].data));
    end

    // Fill to capacity with the consumer stalled
    do_reset();
    for (int i = 0; i < 256; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      tick();
    end
    check("full_fill", 64'(fill_bytes), 64'(256));
    check("full_wr_ready", 64'(wr_ready), 64'(0));
    check("full_rd_valid", 64'(rd_valid), 64'(1));
    wr_data = 8'hEE;
    #1;
    check("full_extra_enA", 64'(ram_enA), 64'(0));
    tick();
    check("full_extra_fill", 64'(fill_bytes), 64'(256));
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pop1_fill", 64'(fill_bytes), 64'(252));
    check("pop1_wr_ready", 64'(wr_ready), 64'(1));

    // Stall in VALID while writing: output word and port B must not move
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      #1;
      check($sformatf("stall%0d_rd_valid", k), 64'(rd_valid), 64'(1));
      check($sformatf("stall%0d_enB", k), 64'(ram_enB), 64'(0));
      check($sformatf("stall%0d_rd_data", k), 64'(rd_data), 64'(sb[0]));
      tick();
    end
    check("stall_fill", 64'(fill_bytes), 64'(256));

    // Back-to-back pops: 64 stored words drain in 64 cycles
    drain("drain_full", n);
    check("drain_full_cycles", 64'(n), 64'(64));

    // Streaming 1024 bytes through pointer wrap
    do_reset();
    pops = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      tick();
    end
    drain("stream", n);
    check("stream_words", 64'(pops), 64'(256));

    // Reset with two words and one byte stored discards everything
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h60 + i);
      tick();
    end
    wr_valid = 1'b0;
    check("pre_rst_fill", 64'(fill_bytes), 64'(9));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_fill", 64'(fill_bytes), 64'(0));
    check("midrst_rd_valid", 64'(rd_valid), 64'(0));
    check("midrst_wr_ready", 64'(wr_ready), 64'(1));
    check("midrst_enA", 64'(ram_enA), 64'(0));
    check("midrst_enB", 64'(ram_enB), 64'(0));
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'hA1 + i);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    check("post_rst_rd_valid", 64'(rd_valid), 64'(1));
    check("post_rst_rd_data", 64'(rd_data), 64'(32'hA4A3A2A1));
    drain("post_rst", n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
